// File: rtl/cc_goal_level_tracker.sv
// Goal-row level-completion tracker: counts goals, confirms a full row for HOLD_CYCLES
// evaluations, holds the level win until acknowledged, then advances the level or ends the game.
// States: PLAY watch row | CONFIRM counting full evals | WIN wait for ack | CLEAR one-cycle clear | DONE game over
module cc_goal_level_tracker #(
    parameter int WIDTH       = 8,
    parameter int NUM_LEVELS  = 4,
    parameter int HOLD_CYCLES = 2,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic             CC_GOALTRACKER_CLOCK_50,
    input  logic             CC_GOALTRACKER_RESET_InHigh,
    input  logic [WIDTH-1:0] CC_GOALTRACKER_GOALROW_InBUS,
    input  logic             CC_GOALTRACKER_ACK_InHigh,
    input  logic             CC_GOALTRACKER_RESTART_InHigh,
    output logic             CC_GOALTRACKER_WinL_OutHigh,
    output logic             CC_GOALTRACKER_CLEAR_OutHigh,
    output logic             CC_GOALTRACKER_NEWGOAL_OutHigh,
    output logic [CW-1:0]    CC_GOALTRACKER_GOALCOUNT_OutBUS,
    output logic [LW-1:0]    CC_GOALTRACKER_LEVEL_OutBUS,
    output logic             CC_GOALTRACKER_GAMEWIN_OutHigh
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_PLAY,
        S_CONFIRM,
        S_WIN,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic [WIDTH-1:0] row_prev_q, row_prev_d;
    logic [HW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    level_q, level_d;

    logic          full;
    logic          level_last;
    logic [HW-1:0] cnt_inc;
    logic [CW-1:0] goal_count;

    always_ff @(posedge CC_GOALTRACKER_CLOCK_50 or posedge CC_GOALTRACKER_RESET_InHigh) begin
        if (CC_GOALTRACKER_RESET_InHigh) begin
            state_q    <= S_PLAY;
            row_q      <= '0;
            row_prev_q <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_prev_q <= row_prev_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
        end
    end

    always_comb begin
        row_d      = CC_GOALTRACKER_GOALROW_InBUS;
        row_prev_d = row_q;
    end

    always_comb begin
        goal_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            goal_count = goal_count + CW'(row_q[i]);
        end
    end

    assign full       = &row_q;
    assign level_last = (level_q == LW'(NUM_LEVELS - 1));
    assign cnt_inc    = cnt_q + HW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (CC_GOALTRACKER_RESTART_InHigh) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            level_d = '0;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (full) begin
                        if (HOLD_CYCLES == 1) begin
                            state_d = S_WIN;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_CONFIRM;
                            cnt_d   = HW'(1);
                        end
                    end
                end
                S_CONFIRM: begin
                    if (!full) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else if (cnt_inc == HW'(HOLD_CYCLES)) begin
                        state_d = S_WIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_WIN: begin
                    // Row changes are ignored here; only the game FSM can release a win.
                    if (CC_GOALTRACKER_ACK_InHigh) begin
                        if (level_last) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CLEAR;
                            level_d = level_q + LW'(1);
                        end
                    end
                end
                S_CLEAR: state_d = S_PLAY;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_PLAY;
            endcase
        end
    end

    assign CC_GOALTRACKER_WinL_OutHigh     = (state_q == S_WIN);
    assign CC_GOALTRACKER_CLEAR_OutHigh    = (state_q == S_CLEAR);
    assign CC_GOALTRACKER_GAMEWIN_OutHigh  = (state_q == S_DONE);
    assign CC_GOALTRACKER_NEWGOAL_OutHigh  = ((state_q == S_PLAY) || (state_q == S_CONFIRM))
                                             && |(row_q & ~row_prev_q);
    assign CC_GOALTRACKER_GOALCOUNT_OutBUS = goal_count;
    assign CC_GOALTRACKER_LEVEL_OutBUS     = level_q;

endmodule

// File: tb/tb_cc_goal_level_tracker.sv
// Scoreboard bench: dut_a (HOLD=2, 4 levels) and dut_b (HOLD=3, 2 levels) share stimulus;
// each task queues per-cycle stimulus with the expected outputs and compares after every edge.
module tb_cc_goal_level_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] row = '0;
    logic       ack = 1'b0;
    logic       restart = 1'b0;

    logic       win_a, clr_a, ng_a, gw_a;
    logic [3:0] cnt_a;
    logic [1:0] lvl_a;
    logic       win_b, clr_b, ng_b, gw_b;
    logic [3:0] cnt_b;
    logic [0:0] lvl_b;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] row;
        logic       ack;
        logic       rs;
    } stim_t;

    typedef struct {
        string      name;
        logic [9:0] v;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    // Packed view {win, clear, newgoal, count[3:0], level[1:0], gamewin}
    logic [9:0] obs_a, obs_b;
    assign obs_a = {win_a, clr_a, ng_a, cnt_a, lvl_a, gw_a};
    assign obs_b = {win_b, clr_b, ng_b, cnt_b, 1'b0, lvl_b, gw_b};

    cc_goal_level_tracker #(.WIDTH(8), .NUM_LEVELS(4), .HOLD_CYCLES(2)) dut_a (
        .CC_GOALTRACKER_CLOCK_50        (clk),
        .CC_GOALTRACKER_RESET_InHigh    (rst),
        .CC_GOALTRACKER_GOALROW_InBUS   (row),
        .CC_GOALTRACKER_ACK_InHigh      (ack),
        .CC_GOALTRACKER_RESTART_InHigh  (restart),
        .CC_GOALTRACKER_WinL_OutHigh    (win_a),
        .CC_GOALTRACKER_CLEAR_OutHigh   (clr_a),
        .CC_GOALTRACKER_NEWGOAL_OutHigh (ng_a),
        .CC_GOALTRACKER_GOALCOUNT_OutBUS(cnt_a),
        .CC_GOALTRACKER_LEVEL_OutBUS    (lvl_a),
        .CC_GOALTRACKER_GAMEWIN_OutHigh (gw_a)
    );

    cc_goal_level_tracker #(.WIDTH(8), .NUM_LEVELS(2), .HOLD_CYCLES(3)) dut_b (
        .CC_GOALTRACKER_CLOCK_50        (clk),
        .CC_GOALTRACKER_RESET_InHigh    (rst),
        .CC_GOALTRACKER_GOALROW_InBUS   (row),
        .CC_GOALTRACKER_ACK_InHigh      (ack),
        .CC_GOALTRACKER_RESTART_InHigh  (restart),
        .CC_GOALTRACKER_WinL_OutHigh    (win_b),
        .CC_GOALTRACKER_CLEAR_OutHigh   (clr_b),
        .CC_GOALTRACKER_NEWGOAL_OutHigh (ng_b),
        .CC_GOALTRACKER_GOALCOUNT_OutBUS(cnt_b),
        .CC_GOALTRACKER_LEVEL_OutBUS    (lvl_b),
        .CC_GOALTRACKER_GAMEWIN_OutHigh (gw_b)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [7:0] r, input logic a, input logic rs,
                       input logic w, input logic c, input logic n,
                       input logic [3:0] cnt, input logic [1:0] lvl, input logic gw,
                       input string nm);
        stim_t s;
        exp_t  e;
        s.row = r; s.ack = a; s.rs = rs;
        e.name = $sformatf("%s#%0d", nm, exp_q.size());
        e.v = {w, c, n, cnt, lvl, gw};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        row = '0; ack = 1'b0; restart = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        do_reset();
        n_cmp++;
        if (obs_a !== 10'b0) begin
            n_fail++; $display("FAIL reset_init: got %b expected %b", obs_a, 10'b0);
        end
        add(8'hFF, 0, 0, 0, 0, 1, 4'd8, 2'd0, 0, "rst_pre");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "rst_pre");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); row = s.row; ack = s.ack; restart = s.rs;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a !== e.v) begin
                n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v);
            end
        end
        // Asynchronous assert in the middle of CONFIRM, row still all-ones
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_a !== 10'b0) begin
            n_fail++; $display("FAIL reset_async: got %b expected %b", obs_a, 10'b0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (obs_b !== 10'b0) begin
            n_fail++; $display("FAIL reset_held: got %b expected %b", obs_b, 10'b0);
        end
        rst = 1'b0;
        add(8'hFF, 0, 0, 0, 0, 1, 4'd8, 2'd0, 0, "rst_post");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "rst_post");
        add(8'hFF, 0, 0, 1, 0, 0, 4'd8, 2'd0, 0, "rst_post");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); row = s.row; ack = s.ack; restart = s.rs;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a !== e.v) begin
                n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v);
            end
        end
    endtask

    task automatic test_win_latency();
        stim_t s;
        exp_t  e;
        do_reset();
        add(8'hFF, 0, 0, 0, 0, 1, 4'd8, 2'd0, 0, "lat");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "lat");
        add(8'hFF, 0, 0, 1, 0, 0, 4'd8, 2'd0, 0, "lat_win");
        for (int i = 0; i < 20; i++) add(8'hFF, 0, 0, 1, 0, 0, 4'd8, 2'd0, 0, "win_hold");
        add(8'h00, 0, 0, 1, 0, 0, 4'd0, 2'd0, 0, "win_rowchg");
        add(8'h00, 0, 0, 1, 0, 0, 4'd0, 2'd0, 0, "win_rowchg");
        add(8'hFF, 0, 0, 1, 0, 0, 4'd8, 2'd0, 0, "win_no_newgoal");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); row = s.row; ack = s.ack; restart = s.rs;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a !== e.v) begin
                n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v);
            end
        end
    endtask

    task automatic test_goal_events();
        stim_t s;
        exp_t  e;
        do_reset();
        add(8'h00, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, "goal");
        add(8'h01, 0, 0, 0, 0, 1, 4'd1, 2'd0, 0, "goal");
        add(8'h01, 0, 0, 0, 0, 0, 4'd1, 2'd0, 0, "goal");
        add(8'h05, 0, 0, 0, 0, 1, 4'd2, 2'd0, 0, "goal");
        add(8'h04, 0, 0, 0, 0, 0, 4'd1, 2'd0, 0, "goal_drop");
        add(8'h04, 0, 0, 0, 0, 0, 4'd1, 2'd0, 0, "goal_drop");
        add(8'h7F, 0, 0, 0, 0, 1, 4'd7, 2'd0, 0, "goal_many");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); row = s.row; ack = s.ack; restart = s.rs;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a !== e.v) begin
                n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v);
            end
        end
    endtask

    task automatic test_level_advance();
        stim_t s;
        exp_t  e;
        do_reset();
        add(8'hFF, 0, 0, 0, 0, 1, 4'd8, 2'd0, 0, "adv");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "adv");
        add(8'hFF, 0, 0, 1, 0, 0, 4'd8, 2'd0, 0, "adv_win");
        add(8'h00, 0, 0, 1, 0, 0, 4'd0, 2'd0, 0, "adv_win");
        add(8'h00, 1, 0, 0, 1, 0, 4'd0, 2'd1, 0, "adv_clear");
        add(8'h00, 0, 0, 0, 0, 0, 4'd0, 2'd1, 0, "adv_play");
        for (int i = 0; i < 4; i++) add(8'h00, 0, 0, 0, 0, 0, 4'd0, 2'd1, 0, "adv_nowin");
        add(8'h00, 1, 0, 0, 0, 0, 4'd0, 2'd1, 0, "ack_ignored");
        add(8'h00, 1, 0, 0, 0, 0, 4'd0, 2'd1, 0, "ack_ignored");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); row = s.row; ack = s.ack; restart = s.rs;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a !== e.v) begin
                n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v);
            end
        end
    endtask

    // Continues from level 1 with ACK held high: every level still needs its own detection.
    task automatic test_back_to_back();
        stim_t s;
        exp_t  e;
        add(8'hFF, 1, 0, 0, 0, 1, 4'd8, 2'd1, 0, "b2b");
        add(8'hFF, 1, 0, 0, 0, 0, 4'd8, 2'd1, 0, "b2b");
        add(8'hFF, 1, 0, 1, 0, 0, 4'd8, 2'd1, 0, "b2b_win1");
        add(8'hFF, 1, 0, 0, 1, 0, 4'd8, 2'd2, 0, "b2b_clr");
        add(8'hFF, 1, 0, 0, 0, 0, 4'd8, 2'd2, 0, "b2b");
        add(8'hFF, 1, 0, 0, 0, 0, 4'd8, 2'd2, 0, "b2b");
        add(8'hFF, 1, 0, 1, 0, 0, 4'd8, 2'd2, 0, "b2b_win2");
        add(8'hFF, 1, 0, 0, 1, 0, 4'd8, 2'd3, 0, "b2b_clr");
        add(8'hFF, 1, 0, 0, 0, 0, 4'd8, 2'd3, 0, "b2b");
        add(8'hFF, 1, 0, 0, 0, 0, 4'd8, 2'd3, 0, "b2b");
        add(8'hFF, 1, 0, 1, 0, 0, 4'd8, 2'd3, 0, "b2b_win3");
        add(8'hFF, 1, 0, 0, 0, 0, 4'd8, 2'd3, 1, "b2b_done");
        for (int i = 0; i < 3; i++) add(8'h00, 0, 0, 0, 0, 0, 4'd0, 2'd3, 1, "done_hold");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd3, 1, "done_no_newgoal");
        add(8'hFF, 0, 1, 0, 1, 0, 4'd8, 2'd0, 0, "restart_clr");
        add(8'h00, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, "restart_play");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); row = s.row; ack = s.ack; restart = s.rs;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a !== e.v) begin
                n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v);
            end
        end
    endtask

    task automatic test_glitch_reject();
        stim_t s;
        exp_t  e;
        do_reset();
        add(8'hFF, 0, 0, 0, 0, 1, 4'd8, 2'd0, 0, "glitch");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "glitch");
        add(8'hFE, 0, 0, 0, 0, 0, 4'd7, 2'd0, 0, "glitch_fe");
        for (int i = 0; i < 4; i++) add(8'hFE, 0, 0, 0, 0, 0, 4'd7, 2'd0, 0, "glitch_nowin");
        add(8'hFF, 0, 0, 0, 0, 1, 4'd8, 2'd0, 0, "refull");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "refull");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "refull");
        add(8'hFF, 0, 0, 1, 0, 0, 4'd8, 2'd0, 0, "refull_win");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); row = s.row; ack = s.ack; restart = s.rs;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs_b !== e.v) begin
                n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_b, e.v);
            end
        end
    endtask

    // Continues dut_b from WIN at level 0.
    task automatic test_game_end();
        stim_t s;
        exp_t  e;
        add(8'h00, 1, 0, 0, 1, 0, 4'd0, 2'd1, 0, "end_clr");
        add(8'h00, 0, 0, 0, 0, 0, 4'd0, 2'd1, 0, "end");
        add(8'hFF, 0, 0, 0, 0, 1, 4'd8, 2'd1, 0, "end");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd1, 0, "end");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd1, 0, "end");
        add(8'hFF, 0, 0, 1, 0, 0, 4'd8, 2'd1, 0, "end_win");
        add(8'hFF, 1, 0, 0, 0, 0, 4'd8, 2'd1, 1, "end_gamewin");
        for (int i = 0; i < 3; i++) add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd1, 1, "end_hold");
        add(8'hFF, 0, 1, 0, 1, 0, 4'd8, 2'd0, 0, "end_restart");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "end_replay");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "end_replay");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "end_replay");
        add(8'hFF, 0, 0, 1, 0, 0, 4'd8, 2'd0, 0, "end_rewin");
        add(8'hFF, 1, 1, 0, 1, 0, 4'd8, 2'd0, 0, "restart_over_ack");
        add(8'hFF, 0, 0, 0, 0, 0, 4'd8, 2'd0, 0, "restart_over_ack");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); row = s.row; ack = s.ack; restart = s.rs;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs_b !== e.v) begin
                n_fail++; $display("FAIL %s: got %b expected %b", e.name, obs_b, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_win_latency();
        test_goal_events();
        test_level_advance();
        test_back_to_back();
        test_glitch_reject();
        test_game_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
